// File: rtl/mux2_pipe.sv
// 2:1 datapath multiplexer with optional output register, valid flag and hold.
// Optional even-parity output y_par is built when MUX_PARITY_EN is defined.
module mux2_pipe #(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             sel_q
`ifdef MUX_PARITY_EN
    ,
    output logic             y_par
`endif
);

    function automatic logic [WIDTH-1:0] mux_sel(input logic [WIDTH-1:0] da,
                                                 input logic [WIDTH-1:0] db,
                                                 input logic             s);
        return s ? db : da;
    endfunction

    logic [WIDTH-1:0] mux_d_p0;

    assign mux_d_p0 = mux_sel(a, b, sel);

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] y_p1;
        logic             vld_p1;
        logic             sel_p1;

        // stage p0 -> p1: capture on en, hold data otherwise; valid only marks fresh captures
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_p1   <= '0;
                sel_p1 <= 1'b0;
                vld_p1 <= 1'b0;
            end else if (en) begin
                y_p1   <= mux_d_p0;
                sel_p1 <= sel;
                vld_p1 <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end

        assign y       = y_p1;
        assign sel_q   = sel_p1;
        assign y_valid = vld_p1;

`ifdef MUX_PARITY_EN
        logic par_p1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                par_p1 <= 1'b0;
            end else if (en) begin
                par_p1 <= ^mux_d_p0;
            end
        end

        assign y_par = par_p1;
`endif
    end else begin : g_comb
        assign y       = mux_d_p0;
        assign sel_q   = sel;
        assign y_valid = en & ~rst;
`ifdef MUX_PARITY_EN
        assign y_par   = ^mux_d_p0;
`endif
    end

endmodule

// File: tb/tb_mux2_pipe.sv
// Scoreboard bench for mux2_pipe: one registered and one combinational instance.
// Parity checks are compiled in when MUX_PARITY_EN is defined.
module tb_mux2_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, ca, cb;
    logic        sel, en, csel, cen;
    logic [31:0] y, cy;
    logic        y_valid, sel_q, cy_valid, csel_q;
`ifdef MUX_PARITY_EN
    logic        y_par, cy_par;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] y;
        logic        v;
        logic        s;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_y;
    logic        m_v, m_s;

    always #5 clk = ~clk;

    mux2_pipe #(.WIDTH(32), .REG_OUT(1'b1)) dut_r (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .en(en),
        .y(y), .y_valid(y_valid), .sel_q(sel_q)
`ifdef MUX_PARITY_EN
        , .y_par(y_par)
`endif
    );

    mux2_pipe #(.WIDTH(32), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .a(ca), .b(cb), .sel(csel), .en(cen),
        .y(cy), .y_valid(cy_valid), .sel_q(csel_q)
`ifdef MUX_PARITY_EN
        , .y_par(cy_par)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] ey, input logic ev, input logic es);
        chk({tag, ".y"}, {32'h0, y}, {32'h0, ey});
        chk({tag, ".y_valid"}, {63'h0, y_valid}, {63'h0, ev});
        chk({tag, ".sel_q"}, {63'h0, sel_q}, {63'h0, es});
`ifdef MUX_PARITY_EN
        chk({tag, ".y_par"}, {63'h0, y_par}, {63'h0, ^ey});
`endif
    endtask

    // Drive one vector at the falling edge, queue its expected result, compare after the next rise.
    task automatic step(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic te, input string tag);
        exp_t e;
        @(negedge clk);
        a   = ta;
        b   = tb_v;
        sel = ts;
        en  = te;
        if (te) begin
            m_y = ts ? tb_v : ta;
            m_s = ts;
        end
        m_v = te;
        sb.push_back('{m_y, m_v, m_s, tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk_reg(e.tag, e.y, e.v, e.s);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        a    = '0; b  = '0; sel  = 1'b0; en  = 1'b0;
        ca   = '0; cb = '0; csel = 1'b0; cen = 1'b0;
        m_y  = '0; m_v = 1'b0; m_s = 1'b0;

        #50;
        chk_reg("reset_held", 32'h0, 1'b0, 1'b0);
        #50;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reg("after_release", 32'h0, 1'b0, 1'b0);

        step(32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, "cap_a");
        step(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, "cap_b");
        step(32'h00000000, 32'h12345678, 1'b1, 1'b0, "hold_en0");

        // Inputs wiggling between edges must not reach the register.
        a   = 32'h0BADF00D;
        sel = 1'b0;
        #2;
        chk("between_edges.y", {32'h0, y}, {32'h0, m_y});

        rst = 1'b1;
        #1;
        chk_reg("async_reset", 32'h0, 1'b0, 1'b0);
        m_y = '0; m_v = 1'b0; m_s = 1'b0;
        en  = 1'b1;
        a   = 32'h5;
        @(posedge clk);
        #1;
        chk_reg("reset_blocks_capture", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1, "first_after_reset");

        step(32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1, "a_eq_b_s0");
        step(32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, "a_eq_b_s1");
        step(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, "all_ones");

`ifdef MUX_PARITY_EN
        step(32'h00000001, 32'h0, 1'b0, 1'b1, "par_one");
        step(32'h00000003, 32'h0, 1'b0, 1'b1, "par_two");
`endif

        for (int i = 0; i < 16; i++) begin
            step($urandom, $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
        end

        ca   = 32'hFFFFFFFF;
        cb   = 32'h00000001;
        csel = 1'b0;
        cen  = 1'b1;
        #1;
        chk("comb_sel0.y", {32'h0, cy}, {32'h0, 32'hFFFFFFFF});
        chk("comb_sel0.sel_q", {63'h0, csel_q}, 64'd0);
        chk("comb_sel0.valid", {63'h0, cy_valid}, 64'd1);
`ifdef MUX_PARITY_EN
        chk("comb_sel0.y_par", {63'h0, cy_par}, 64'd0);
`endif
        csel = 1'b1;
        #1;
        chk("comb_sel1.y", {32'h0, cy}, {32'h0, 32'h00000001});
        chk("comb_sel1.sel_q", {63'h0, csel_q}, 64'd1);
`ifdef MUX_PARITY_EN
        chk("comb_sel1.y_par", {63'h0, cy_par}, 64'd1);
`endif
        cen = 1'b0;
        #1;
        chk("comb_en0.valid", {63'h0, cy_valid}, 64'd0);
        cen = 1'b1;
        rst = 1'b1;
        #1;
        chk("comb_rst.valid", {63'h0, cy_valid}, 64'd0);
        chk("comb_rst.y", {32'h0, cy}, {32'h0, 32'h00000001});
        rst = 1'b0;
        #1;
        chk("comb_rel.valid", {63'h0, cy_valid}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
